// File: rtl/lcd_hd44780_responder.sv
// HD44780 character-LCD responder: decodes the E/RS/RW/D bus and keeps the DDRAM/CGRAM contents,
// the address counter and the busy flag. A renderer reads the character RAMs through local ports.
module lcd_hd44780_responder #(
    parameter int SYNC_STAGES       = 2,
    parameter int BUSY_CYCLES       = 1850,
    parameter int CLEAR_BUSY_CYCLES = 76000
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data_i,
    output logic [7:0] lcd_data_o,
    output logic       lcd_data_oe,
    input  logic [6:0] disp_rd_addr,
    output logic [7:0] disp_rd_data,
    input  logic [5:0] cg_rd_addr,
    output logic [7:0] cg_rd_data,
    output logic       busy,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       two_line,
    output logic       four_bit,
    output logic       err_busy_wr
);
    localparam int MAXB = (BUSY_CYCLES > CLEAR_BUSY_CYCLES) ? BUSY_CYCLES : CLEAR_BUSY_CYCLES;
    localparam int CW   = $clog2(MAXB + 1);
    localparam logic [CW-1:0] BUSY_N  = CW'(BUSY_CYCLES);
    localparam logic [CW-1:0] CLEAR_N = CW'(CLEAR_BUSY_CYCLES);

    typedef enum logic [1:0] {S_INIT_CLR, S_IDLE, S_CLR, S_BUSY} state_e;

    // DDRAM is stored linearly (line*40+col); ac keeps the HD44780 address form.
    function automatic logic [6:0] ac2lin(input logic [6:0] a, input logic n);
        logic [7:0] l;
        if (n) l = (a[6] ? 8'd40 : 8'd0) + {2'b00, a[5:0]};
        else   l = {1'b0, a};
        if (l >= 8'd80) l = l - 8'd80;
        return l[6:0];
    endfunction

    function automatic logic [6:0] lin2ac(input logic [6:0] l, input logic n);
        return (n && l >= 7'd40) ? l + 7'd24 : l;
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic n, input logic cg,
                                           input logic inc);
        logic [6:0] l;
        if (cg) return {1'b0, inc ? a[5:0] + 6'd1 : a[5:0] - 6'd1};
        l = ac2lin(a, n);
        if (inc) l = (l == 7'd79) ? 7'd0 : l + 7'd1;
        else     l = (l == 7'd0) ? 7'd79 : l - 7'd1;
        return lin2ac(l, n);
    endfunction

    logic [SYNC_STAGES-1:0][10:0] sync_q;
    logic       e_s, rs_s, rw_s;
    logic [7:0] d_s;
    logic       e_prev_q, cap_rs_q, cap_rw_q;
    logic [7:0] cap_d_q;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    fill_q, fill_d, ac_q, ac_d;
    logic          id_q, id_d, cgt_q, cgt_d, dl_q, dl_d, n_q, n_d;
    logic          dsp_q, dsp_d, cur_q, cur_d, blk_q, blk_d, err_q, err_d;
    logic          phase_q, phase_d, oe_q, oe_d;
    logic [3:0]    nib_q, nib_d;
    logic [7:0]    dout_q, dout_d, disp_q, cgrd_q;

    logic [7:0] dd_mem [80];
    logic [7:0] cg_mem [64];
    logic       dd_we, cg_we;
    logic [6:0] dd_wa;
    logic [7:0] dd_wd;

    logic       e_rise, e_fall, act;
    logic [7:0] act_b, rd_val;
    logic [6:0] ac_lin;

    assign {e_s, rs_s, rw_s, d_s} = sync_q[SYNC_STAGES-1];
    assign e_rise = e_s & ~e_prev_q;
    assign e_fall = ~e_s & e_prev_q;
    // In 4-bit mode only the second nibble's falling edge completes a transfer.
    assign act    = e_fall & (dl_q | phase_q);
    assign act_b  = dl_q ? cap_d_q : {nib_q, cap_d_q[7:4]};
    assign ac_lin = ac2lin(ac_q, n_q);
    assign busy   = (state_q != S_IDLE);
    assign rd_val = !rs_s ? {busy, ac_q} : (cgt_q ? cg_mem[ac_q[5:0]] : dd_mem[ac_lin]);

    always_comb begin
        state_d = state_q;  cnt_d = cnt_q;    fill_d  = fill_q;   ac_d  = ac_q;
        id_d    = id_q;     cgt_d = cgt_q;    dl_d    = dl_q;     n_d   = n_q;
        dsp_d   = dsp_q;    cur_d = cur_q;    blk_d   = blk_q;    err_d = err_q;
        phase_d = phase_q;  nib_d = nib_q;    oe_d    = oe_q;     dout_d = dout_q;
        dd_we   = 1'b0;     dd_wa = fill_q;   dd_wd   = 8'h20;    cg_we = 1'b0;

        case (state_q)
            S_INIT_CLR, S_CLR: begin
                dd_we  = 1'b1;
                fill_d = fill_q + 7'd1;
                if (fill_q == 7'd79) begin
                    fill_d = '0;
                    if (state_q == S_CLR) begin
                        state_d = S_BUSY;
                        cnt_d   = CLEAR_N;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: ;
        endcase

        if (e_rise && rw_s) begin
            oe_d   = 1'b1;
            dout_d = dl_q ? rd_val : (phase_q ? {rd_val[3:0], 4'h0} : {rd_val[7:4], 4'h0});
        end
        if (e_fall) begin
            oe_d    = 1'b0;
            phase_d = dl_q ? 1'b0 : ~phase_q;
            if (!phase_q) nib_d = cap_d_q[7:4];
        end

        if (act) begin
            if (cap_rw_q) begin
                if (cap_rs_q) begin
                    if (busy) err_d = 1'b1;
                    else      ac_d  = ac_step(ac_q, n_q, cgt_q, id_q);
                end
            end else if (busy) begin
                err_d = 1'b1;
            end else begin
                state_d = S_BUSY;
                cnt_d   = BUSY_N;
                if (cap_rs_q) begin
                    if (cgt_q) cg_we = 1'b1;
                    else begin
                        dd_we = 1'b1;
                        dd_wa = ac_lin;
                        dd_wd = act_b;
                    end
                    ac_d = ac_step(ac_q, n_q, cgt_q, id_q);
                end else begin
                    // The entry-mode S bit has no visible effect here, so it is not kept.
                    casez (act_b)
                        8'b1???????: begin ac_d = lin2ac(ac2lin(act_b[6:0], n_q), n_q); cgt_d = 1'b0; end
                        8'b01??????: begin ac_d = {1'b0, act_b[5:0]}; cgt_d = 1'b1; end
                        8'b001?????: begin dl_d = act_b[4]; n_d = act_b[3]; end
                        8'b0001????: if (!act_b[3]) ac_d = ac_step(ac_q, n_q, cgt_q, act_b[2]);
                        8'b00001???: {dsp_d, cur_d, blk_d} = act_b[2:0];
                        8'b000001??: id_d = act_b[1];
                        8'b0000001?: begin ac_d = '0; cgt_d = 1'b0; cnt_d = CLEAR_N; end
                        8'b00000001: begin
                            ac_d = '0; cgt_d = 1'b0; id_d = 1'b1;
                            fill_d = '0; state_d = S_CLR;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync_q   <= '0;
            e_prev_q <= 1'b0;  cap_rs_q <= 1'b0;  cap_rw_q <= 1'b0;  cap_d_q <= '0;
            state_q  <= S_INIT_CLR;
            cnt_q    <= '0;    fill_q <= '0;      ac_q <= '0;
            id_q     <= 1'b1;  cgt_q  <= 1'b0;    dl_q <= 1'b1;      n_q <= 1'b0;
            dsp_q    <= 1'b0;  cur_q  <= 1'b0;    blk_q <= 1'b0;     err_q <= 1'b0;
            phase_q  <= 1'b0;  nib_q  <= '0;      oe_q <= 1'b0;      dout_q <= '0;
            disp_q   <= '0;    cgrd_q <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], lcd_e, lcd_rs, lcd_rw, lcd_data_i};
            e_prev_q <= e_s;
            if (e_s) {cap_rs_q, cap_rw_q, cap_d_q} <= {rs_s, rw_s, d_s};
            state_q  <= state_d;  cnt_q <= cnt_d;  fill_q <= fill_d;  ac_q <= ac_d;
            id_q     <= id_d;     cgt_q <= cgt_d;  dl_q <= dl_d;      n_q <= n_d;
            dsp_q    <= dsp_d;    cur_q <= cur_d;  blk_q <= blk_d;    err_q <= err_d;
            phase_q  <= phase_d;  nib_q <= nib_d;  oe_q <= oe_d;      dout_q <= dout_d;
            disp_q   <= (disp_rd_addr < 7'd80) ? dd_mem[disp_rd_addr] : 8'h00;
            cgrd_q   <= cg_mem[cg_rd_addr];
        end
    end

    // Non-blocking writes make a same-cycle local read return the old byte.
    always_ff @(posedge clk_clk) begin
        if (dd_we) dd_mem[dd_wa] <= dd_wd;
        if (cg_we) cg_mem[ac_q[5:0]] <= act_b;
    end

    assign lcd_data_o   = dout_q;
    assign lcd_data_oe  = oe_q;
    assign disp_rd_data = disp_q;
    assign cg_rd_data   = cgrd_q;
    assign ac           = ac_q;
    assign disp_on      = dsp_q;
    assign cursor_on    = cur_q;
    assign blink_on     = blk_q;
    assign two_line     = n_q;
    assign four_bit     = ~dl_q;
    assign err_busy_wr  = err_q;

endmodule
